// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared state encoding and defaults for the tri-state bus responder.
package tri_bus_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int ADDR_W_DEF      = 4;
    localparam int TURN_CYCLES_DEF = 1;
    localparam int RW_BIT          = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_TURN,
        ST_DRIVE,
        ST_RELEASE
    } state_e;

endpackage

// File: rtl/tri_bus_regfile.sv
// tri_bus_regfile: register file with synchronous write, asynchronous read, and synchronous clear.
module tri_bus_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/tri_bus_responder.sv
// tri_bus_responder: target side of a half-duplex tri-state bus; services register
// writes and drives read data after a turnaround, flagging initiator collisions.
module tri_bus_responder
    import tri_bus_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    inout  wire  [DATA_W-1:0] io_bus,
    input  logic              clr_collision,
    output logic              rsp_valid,
    output logic              bus_oe,
    output logic              busy,
    output logic              collision
);

    localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rsp_valid_q, bus_oe_q, busy_q, collision_q;
    logic [DATA_W-1:0] rdata;
    logic              we;
    logic              owns_bus;

    assign we       = (state_q == ST_WDATA) && cmd_valid;
    assign owns_bus = (state_q == ST_TURN) || (state_q == ST_DRIVE) || (state_q == ST_RELEASE);

    tri_bus_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .addr_i  (addr_q),
        .wdata_i (io_bus),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            bus_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            bus_oe_q    <= 1'b0;
            if (clr_collision) collision_q <= 1'b0;
            // A byte arriving while we own the bus is never decoded; a new collision overrides clear.
            if (cmd_valid && owns_bus) begin
                collision_q <= 1'b1;
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (cmd_valid) begin
                        addr_q  <= io_bus[ADDR_W-1:0];
                        cnt_q   <= CNT_W'(TURN_CYCLES - 1);
                        state_q <= io_bus[RW_BIT] ? ST_TURN : ST_WDATA;
                        busy_q  <= 1'b1;
                    end
                    ST_WDATA: if (cmd_valid) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    ST_TURN: if (cnt_q == '0) begin
                        state_q     <= ST_DRIVE;
                        bus_oe_q    <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end else cnt_q <= cnt_q - 1'b1;
                    ST_DRIVE: state_q <= ST_RELEASE;
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign bus_oe    = bus_oe_q;
    assign busy      = busy_q;
    assign collision = collision_q;
    assign io_bus    = (bus_oe_q && !cmd_valid) ? rdata : {DATA_W{1'bz}};

endmodule

// File: doc/tri_bus_responder.md
# tri_bus_responder

Target-side peer for the shared 8-bit bidirectional tri-state bus driven by `tri_io_example`-style initiators. It decodes command bytes sampled from the bus, services writes into a 16×8 register file, and answers reads by driving the bus itself after an enforced turnaround. It sits on the far end of the `io_pin` net and owns the responder half of the half-duplex handshake, including bus-collision detection.

## Interface
- `DATA_W`, 8, bus and register width
- `ADDR_W`, 4, register address width; file depth = 2^ADDR_W
- `TURN_CYCLES`, 1, idle bus cycles between initiator release and responder drive (≥1)

- `clk`  input  1  rising-edge clock, single domain
- `rst`  input  1  synchronous, active-high reset
- `cmd_valid`  input  1  initiator is driving a valid byte on `io_bus` this cycle
- `io_bus`  inout  DATA_W  shared tri-state bus
- `clr_collision`  input  1  clears sticky `collision`
- `rsp_valid`  output  1  responder drives read data this cycle
- `bus_oe`  output  1  responder drive request (registered)
- `busy`  output  1  FSM not in IDLE
- `collision`  output  1  sticky: initiator drove while responder owned or was claiming the bus

## Operation
- Command byte: bit7 = R/W (1 = read), bits[ADDR_W-1:0] = address, remaining bits ignored.
- States: IDLE, WDATA, TURN, DRIVE, RELEASE.
- IDLE: `cmd_valid`=1 → latch address; bit7=0 → WDATA, bit7=1 → TURN (turn counter loaded with TURN_CYCLES-1).
- WDATA: waits indefinitely; on `cmd_valid`=1 write bus byte to reg[addr] → IDLE.
- TURN: count down; at 0 → DRIVE. `bus_oe` rises on entry to DRIVE.
- DRIVE: exactly one cycle; `io_bus` = reg[addr], `rsp_valid`=1 → RELEASE.
- RELEASE: one cycle, `bus_oe`=0, bus Z → IDLE. Next command accepted in IDLE only.
- Collision: `cmd_valid`=1 in TURN, DRIVE or RELEASE → `collision` set, FSM to IDLE, that byte is not decoded as a command.
- Pin drive: `io_bus` = (`bus_oe` && !`cmd_valid`) ? read data : Z — combinational gate, so responder never contends in the collision cycle.
- `clr_collision` and a new collision in the same cycle: set wins.
- Register file: all entries 0 after reset; write-then-read same address returns new value.

## Timing
- Reset values: `rsp_valid`=0, `bus_oe`=0, `busy`=0, `collision`=0, `io_bus`=Z, state IDLE, registers 0.
- Reset mid-transaction: next cycle bus is Z, FSM IDLE, partial write discarded.
- Read latency (TURN_CYCLES=1): command at edge N → TURN during N+1, DRIVE/`rsp_valid` during N+2, RELEASE during N+3, IDLE at N+4; read latency = TURN_CYCLES+1 cycles.
- Write: data accepted at first `cmd_valid` edge after command; register updated at that edge.
- All outputs registered except the `io_bus` gate.

## Structure
- Package `tri_bus_pkg`: state enum, `RW_BIT`=7, default widths, TURN_CYCLES default.
- Sub-module `tri_bus_regfile`: 2^ADDR_W×DATA_W, sync write, async read, sync reset to 0.
- Top holds FSM, turn counter, collision flag, tri-state gate.

## Test plan
- Reset, then write cmd 8'h03 + data 8'h5A; read cmd 8'h83 → `rsp_valid` exactly 2 cycles later with `io_bus`=8'h5A, bus Z the cycle after.
- Read unwritten address 8'h8F after reset → 8'h00 driven in DRIVE.
- Initiator asserts `cmd_valid` with 8'hAA during TURN → `collision`=1, no `rsp_valid`, `io_bus` never driven by responder; `clr_collision` → 0.
- Write cmd 8'h07, `cmd_valid` low 5 cycles, then data 8'hC3 → reg7 = 8'hC3, `busy` high throughout wait.
- `rst` asserted in DRIVE → next cycle `bus_oe`=0, `io_bus`=Z, `busy`=0; subsequent read of 8'h83 returns 8'h00.
- TURN_CYCLES=3 instance: read → `rsp_valid` 4 cycles after command edge.
